core_scheduler: RTL and testbench

Per-core instruction sequencer for the small GPU. It fetches instructions from program memory over a valid/ready handshake and holds the current instruction in an instruction register that drives the core's instruction decoder. It steps each instruction through decode, an optional load/store request, execute and writeback. It owns the program counter, issues memory requests to the load/store unit, and generates the single-cycle register-write strobe.

---
 rtl/core_scheduler.sv | 154 +++++++++++++++
 tb/tb_core_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// rtl/core_scheduler.sv - per-core fetch/decode/LSU/execute/writeback sequencer
// Optional watchdog on FETCH/WAIT handshakes is built when SCHED_TIMEOUT_EN is defined.
module core_scheduler #(
  parameter int INST_WIDTH     = 32,
  parameter int PC_WIDTH       = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  fetch_valid,
  output logic [PC_WIDTH-1:0]   fetch_addr,
  input  logic                  fetch_ready,
  input  logic [INST_WIDTH-1:0] fetch_data,
  output logic [INST_WIDTH-1:0] instruction,
  input  logic [3:0]            dec_opcode,
  input  logic                  dec_reg_write,
  input  logic                  dec_mem_read,
  input  logic                  dec_mem_write,
  output logic                  lsu_valid,
  input  logic                  lsu_done,
  output logic                  reg_write_strobe
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_REQUEST = 3'd3,
    S_WAIT    = 3'd4,
    S_EXECUTE = 3'd5,
    S_UPDATE  = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_MAX = '1;

  state_t                r_state;
  state_t                w_next;
  logic [PC_WIDTH-1:0]   r_pc;
  logic [INST_WIDTH-1:0] r_instruction;
  logic                  r_fetch_valid;
  logic                  r_lsu_valid;
  logic                  r_done;
  logic                  r_strobe;
  logic                  w_timeout;
  logic                  w_launch;

  assign w_launch = start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_tcnt;
  logic          r_error;

  // Counter restarts on every state change, so it measures time spent in the current FETCH/WAIT visit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_next != r_state) begin
      r_tcnt <= '0;
    end else if (r_state == S_FETCH || r_state == S_WAIT) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  assign w_timeout = ((r_state == S_FETCH && !fetch_ready) || (r_state == S_WAIT && !lsu_done))
                     && (r_tcnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (r_state == S_DONE && start) begin
      r_error <= 1'b0;
    end else if (w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign error = r_error;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign error            = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_FETCH;
      S_FETCH: begin
        if (fetch_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_DECODE: begin
        if (dec_opcode == 4'hF)                 w_next = S_DONE;
        else if (dec_mem_read || dec_mem_write) w_next = S_REQUEST;
        else                                    w_next = S_EXECUTE;
      end
      S_REQUEST: w_next = S_WAIT;
      S_WAIT: begin
        if (lsu_done)       w_next = S_EXECUTE;
        else if (w_timeout) w_next = S_DONE;
      end
      S_EXECUTE: w_next = S_UPDATE;
      S_UPDATE:  w_next = (r_pc == PC_MAX) ? S_DONE : S_FETCH;
      S_DONE:    if (start) w_next = S_FETCH;
      default:   w_next = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_instruction <= '0;
      r_fetch_valid <= 1'b0;
      r_lsu_valid   <= 1'b0;
      r_done        <= 1'b0;
      r_strobe      <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_fetch_valid <= (w_next == S_FETCH);
      r_lsu_valid   <= (w_next == S_REQUEST);
      r_done        <= (w_next == S_DONE);
      r_strobe      <= (w_next == S_UPDATE) && dec_reg_write;
      if (w_launch) begin
        r_pc <= '0;
      end else if (r_state == S_UPDATE && r_pc != PC_MAX) begin
        r_pc <= r_pc + 1'b1;
      end
      if (r_state == S_FETCH && fetch_ready) begin
        r_instruction <= fetch_data;
      end
    end
  end

  assign state            = r_state;
  assign pc               = r_pc;
  assign fetch_valid      = r_fetch_valid;
  assign fetch_addr       = r_pc;
  assign instruction      = r_instruction;
  assign lsu_valid        = r_lsu_valid;
  assign done             = r_done;
  assign reg_write_strobe = r_strobe;

endmodule

// File: tb/tb_core_scheduler.sv
// tb/tb_core_scheduler.sv - randomized bench for core_scheduler against a cycle-count program model
// Watchdog checks are included when SCHED_TIMEOUT_EN is defined.
module tb_core_scheduler;

  localparam int IW = 32;
  localparam int PW = 4;
  localparam int NI = 1 << PW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          done;
  logic          error;
  logic [2:0]    state;
  logic [PW-1:0] pc;
  logic          fetch_valid;
  logic [PW-1:0] fetch_addr;
  logic          fetch_ready = 1'b0;
  logic [IW-1:0] fetch_data = '0;
  logic [IW-1:0] instruction;
  logic [3:0]    dec_opcode;
  logic          dec_reg_write;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          lsu_valid;
  logic          lsu_done = 1'b0;
  logic          reg_write_strobe;

  int n_vec = 0;
  int n_bad = 0;

  logic [IW-1:0] prog_mem [NI];
  int            fwait [NI];
  int            ldel [NI];

  core_scheduler #(.INST_WIDTH(IW), .PC_WIDTH(PW), .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done(done), .error(error), .state(state),
    .pc(pc), .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_data(fetch_data), .instruction(instruction), .dec_opcode(dec_opcode),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .lsu_valid(lsu_valid), .lsu_done(lsu_done), .reg_write_strobe(reg_write_strobe)
  );

  always #5 clk = ~clk;

  // Decoder: NOP=0 ADD=1 SUB=2 LD=3 ST=4 HALT=F, others are ALU ops without writeback.
  always_comb begin
    dec_opcode    = instruction[31:28];
    dec_reg_write = (dec_opcode == 4'h1) || (dec_opcode == 4'h2) || (dec_opcode == 4'h3);
    dec_mem_read  = (dec_opcode == 4'h3);
    dec_mem_write = (dec_opcode == 4'h4);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [IW-1:0] word(input logic [3:0] op);
    logic [27:0] lo;
    lo = 28'($urandom);
    return {op, lo};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, state, 3'd0);
    check({tag, "_pc"}, pc, 0);
    check({tag, "_instr"}, instruction, 0);
    check({tag, "_flags"}, {fetch_valid, lsu_valid, reg_write_strobe, done, error}, 5'b0);
  endtask

  // Runs prog_mem from a start pulse, answering fetch/LSU with the waits in fwait/ldel.
  task automatic run_prog(input string tag);
    int exp_addr[$];
    int exp_str[$];
    int got_str[$];
    int t = 0, p = 0, li = 0, exp_done = 0, exp_lsu = 0, last = 0;
    int fi = 0, lj = 0, wcnt = 0, lcnt = 0, lsu_hi = 0, done_cyc = 0, addr;
    bit in_fetch = 0, pend = 0;
    logic [3:0] op;

    for (int s = 0; s < NI; s++) begin
      exp_addr.push_back(p);
      last = p;
      t += fwait[s] + 2;
      op = prog_mem[p][31:28];
      if (op == 4'hF) begin
        exp_done = t + 1;
        break;
      end
      if (op == 4'h3 || op == 4'h4) begin
        t += 1 + ldel[li];
        li++;
        exp_lsu++;
      end
      t += 2;
      if (op == 4'h1 || op == 4'h2 || op == 4'h3) exp_str.push_back(t);
      if (p == NI - 1) begin
        exp_done = t + 1;
        break;
      end
      p++;
    end

    @(negedge clk);
    start = 1'b1;
    for (int cyc = 1; cyc <= 600 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        done_cyc = cyc;
      end else begin
        if (state != 3'd0 && $urandom_range(0, 7) == 0) start = 1'b1;
        if (reg_write_strobe) got_str.push_back(cyc);
        if (lsu_valid) lsu_hi++;
        fetch_data = word(4'($urandom));
        if (fetch_valid) begin
          addr = (fi < exp_addr.size()) ? exp_addr[fi] : int'(fetch_addr);
          if (!in_fetch) begin
            in_fetch = 1;
            check({tag, "_fetch_addr"}, fetch_addr, addr);
            wcnt = fwait[fi % NI];
          end
          if (wcnt == 0) begin
            fetch_ready = 1'b1;
            fetch_data  = prog_mem[addr % NI];
            in_fetch    = 0;
            fi++;
          end else begin
            fetch_ready = 1'b0;
            wcnt--;
          end
        end else begin
          fetch_ready = 1'($urandom);
        end
        if (pend) begin
          lcnt--;
          lsu_done = (lcnt == 0);
          if (lcnt == 0) pend = 0;
        end else if (lsu_valid) begin
          pend     = 1;
          lcnt     = ldel[lj % NI];
          lj++;
          lsu_done = 1'b0;
        end else begin
          lsu_done = ($urandom_range(0, 3) == 0);
        end
      end
    end
    fetch_ready = 1'b0;
    lsu_done    = 1'b0;

    check({tag, "_done_cycle"}, done_cyc, exp_done);
    check({tag, "_pc"}, pc, last);
    check({tag, "_state"}, state, 3'd7);
    check({tag, "_error"}, error, 1'b0);
    check({tag, "_n_fetch"}, fi, exp_addr.size());
    check({tag, "_lsu_cycles"}, lsu_hi, exp_lsu);
    check({tag, "_instr"}, instruction, prog_mem[last]);
    check({tag, "_n_strobe"}, got_str.size(), exp_str.size());
    for (int i = 0; i < got_str.size() && i < exp_str.size(); i++)
      check({tag, "_strobe_cycle"}, got_str[i], exp_str[i]);
  endtask

  task automatic clear_waits();
    for (int i = 0; i < NI; i++) begin
      fwait[i] = 0;
      ldel[i]  = 1;
    end
  endtask

  initial begin
    bit reached;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle_hold");

    clear_waits();
    prog_mem[0] = word(4'h1);
    prog_mem[1] = word(4'h2);
    prog_mem[2] = word(4'hF);
    run_prog("add_sub_halt");

    clear_waits();
    ldel[0] = 5;
    prog_mem[0] = word(4'h3);
    prog_mem[1] = word(4'h4);
    prog_mem[2] = word(4'hF);
    run_prog("ld_st");

    clear_waits();
    for (int i = 0; i < NI; i++) prog_mem[i] = word(4'h0);
    run_prog("nop_pc_max");

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NI; i++) begin
        prog_mem[i] = word(4'($urandom_range(0, 14)));
        fwait[i]    = $urandom_range(0, 3);
        ldel[i]     = $urandom_range(1, 6);
      end
      if ($urandom_range(0, 2) != 0) prog_mem[$urandom_range(0, NI - 1)][31:28] = 4'hF;
      run_prog("random");
    end

    // Reset while an LD sits in WAIT; a late lsu_done must not revive it.
    prog_mem[0] = word(4'h3);
    @(negedge clk);
    fetch_data  = prog_mem[0];
    fetch_ready = 1'b1;
    start       = 1'b1;
    reached     = 0;
    for (int i = 0; i < 12 && !reached; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (state == 3'd4) reached = 1;
    end
    check("wait_reached", reached, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    rst_n    = 1'b1;
    lsu_done = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_outputs("post_reset_lsu_done");
    lsu_done    = 1'b0;
    fetch_ready = 1'b0;

`ifdef SCHED_TIMEOUT_EN
    start = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 8) check("to_still_fetch", state, 3'd1);
    end
    check("to_state", state, 3'd7);
    check("to_error", error, 1'b1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("to_restart_state", state, 3'd1);
    check("to_error_cleared", error, 1'b0);
    check("to_restart_addr", fetch_addr, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
